// File: rtl/fixed_point_muldiv_seq_if.sv
// Start/done handshake bundle for the sequential fixed-point multiply/divide unit.
// The requester drives operands through the master modport; the unit answers through slave.
interface fixed_point_muldiv_seq_if #(
  parameter int W = 28
);
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         overflow;
  logic         div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, overflow, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, overflow, div_by_zero
  );
endinterface

// File: rtl/fixed_point_muldiv_seq.sv
// Sequential signed Q(INT_W).(FRAC_W) multiply (shift-add) / divide (restoring) with saturation.
// Define FIXED_POINT_ROUND_EN for round-half-away-from-zero instead of truncation.
module fixed_point_muldiv_seq #(
  parameter int INT_W  = 12,
  parameter int FRAC_W = 16
) (
  input logic                    clk,
  input logic                    reset,
  fixed_point_muldiv_seq_if.slave bus
);
  localparam int W = INT_W + FRAC_W;
`ifdef FIXED_POINT_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int DN = W + FRAC_W + RND;  // dividend/quotient width, one guard bit when rounding
  localparam int MW = 2 * W;
  localparam int CW = $clog2(DN + 1);
  localparam logic [MW-1:0] RND_ADD   = MW'(RND) << (FRAC_W - 1);
  localparam logic [W-1:0]  NEG_LIM_W = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  POS_LIM_W = ~NEG_LIM_W;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic          sign, dz;
  logic [W-1:0]  ma, mb;
  logic [MW-1:0] prod;
  logic [W-1:0]  rem;
  logic [DN-1:0] dvd;
  logic [MW-1:0] mag;
  logic [W-1:0]  result_q;
  logic          overflow_q, dz_q, done_q;

  logic          accept;
  logic          div_zero_req;
  logic [W-1:0]  abs_a, abs_b;
  logic [W:0]    mul_sum;
  logic [W:0]    rem_sh;
  logic          q_bit;
  logic [W-1:0]  lim_w, mag_low, fix_res;
  logic          sat;

  assign accept       = (state == IDLE) && bus.start;
  assign div_zero_req = bus.op && (bus.b == '0);
  assign abs_a        = bus.a[W-1] ? -bus.a : bus.a;
  assign abs_b        = bus.b[W-1] ? -bus.b : bus.b;

  // Shift-add: multiplier sits in the low half of prod and is consumed LSB first.
  assign mul_sum = {1'b0, prod[MW-1:W]} + (prod[0] ? {1'b0, ma} : '0);

  assign rem_sh = {rem, dvd[DN-1]};
  assign q_bit  = (rem_sh >= {1'b0, mb});

  // Negative results may reach 2^(W-1); positive ones stop one short.
  assign lim_w   = sign ? NEG_LIM_W : POS_LIM_W;
  assign sat     = (mag > MW'(lim_w));
  assign mag_low = sat ? lim_w : mag[W-1:0];
  assign fix_res = sign ? -mag_low : mag_low;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = bus.op ? DIV : MUL;
      MUL:  if (cnt == CW'(W))  state_nxt = FIX;
      DIV:  if (cnt == CW'(DN)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      cnt        <= '0;
      sign       <= 1'b0;
      dz         <= 1'b0;
      ma         <= '0;
      mb         <= '0;
      prod       <= '0;
      rem        <= '0;
      dvd        <= '0;
      mag        <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      unique case (state)
        IDLE: if (accept) begin
          sign <= bus.a[W-1] ^ bus.b[W-1];
          dz   <= div_zero_req;
          ma   <= abs_a;
          mb   <= abs_b;
          prod <= {{W{1'b0}}, abs_b};
          rem  <= '0;
          dvd  <= DN'(abs_a) << (FRAC_W + RND);
          // A zero divisor skips the quotient loop and only runs the final step.
          cnt  <= div_zero_req ? CW'(DN) : '0;
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          if (cnt != CW'(W)) prod <= {mul_sum, prod[W-1:1]};
          else               mag  <= (prod + RND_ADD) >> FRAC_W;
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt != CW'(DN)) begin
            rem <= q_bit ? W'(rem_sh - {1'b0, mb}) : rem_sh[W-1:0];
            dvd <= {dvd[DN-2:0], q_bit};
          end else if (RND != 0) begin
            mag <= MW'(dvd >> 1) + MW'(dvd[0]);
          end else begin
            mag <= MW'(dvd);
          end
        end
        FIX: begin
          result_q   <= dz ? lim_w : fix_res;
          overflow_q <= sat && !dz;
          dz_q       <= dz;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.overflow    = overflow_q;
  assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_fixed_point_muldiv_seq.sv
// Self-checking bench: directed vector table, handshake/reset sequences, and random ops
// compared against a plain-arithmetic reference model.
module tb_fixed_point_muldiv_seq;
  localparam int INT_W  = 12;
  localparam int FRAC_W = 16;
  localparam int W      = INT_W + FRAC_W;
`ifdef FIXED_POINT_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int L_MUL = W + 2;
  localparam int L_DIV = W + FRAC_W + 2 + RND;
  localparam int L_DZ  = 2;

  typedef struct packed {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ovf;
    logic         dz;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
    logic         dz;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  fixed_point_muldiv_seq_if #(.W(W)) bus ();

  fixed_point_muldiv_seq #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: exact integer product/quotient on magnitudes, then round/truncate and clamp.
  function automatic exp_t model(input logic o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t            e;
    longint          sa, sb;
    longint unsigned ma, mb, mag, lim, x;
    bit              neg;
    sa  = longint'($signed(aa));
    sb  = longint'($signed(bb));
    neg = aa[W-1] ^ bb[W-1];
    ma  = unsigned'((sa < 0) ? -sa : sa);
    mb  = unsigned'((sb < 0) ? -sb : sb);
    lim = neg ? (64'd1 << (W - 1)) : ((64'd1 << (W - 1)) - 64'd1);
    e   = '0;
    if (o && bb == '0) begin
      e.dz  = 1'b1;
      e.res = aa[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      return e;
    end
    if (!o) begin
      mag = ma * mb;
      if (RND != 0) mag = mag + (64'd1 << (FRAC_W - 1));
      mag = mag >> FRAC_W;
    end else begin
      x   = ma << FRAC_W;
      mag = x / mb;
      if (RND != 0 && 2 * (x % mb) >= mb) mag = mag + 64'd1;
    end
    if (mag > lim) begin
      e.ovf = 1'b1;
      mag   = lim;
    end
    e.res = neg ? W'(-mag) : W'(mag);
    return e;
  endfunction

  // Issues one operation and waits for done; pulse_at>0 injects a stray start at that cycle.
  task automatic do_op(input bit sync, input logic o, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input int pulse_at,
                       output int lat, output bit busy_ok, output bit done_e0);
    if (sync) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = aa;
    bus.b     = bb;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 1'($urandom);
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    busy_ok   = bus.busy;
    done_e0   = bus.done;
    lat       = -1;
    for (int i = 1; i <= 100; i++) begin
      if (i == pulse_at) begin
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.b     = '0;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        lat = i;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic check_op(input string tag, input logic o, input logic [W-1:0] bb,
                          input exp_t e, input int lat, input bit busy_ok, input bit done_e0);
    int exp_lat;
    exp_lat = !o ? L_MUL : ((bb == '0) ? L_DZ : L_DIV);
    check({tag, ".result"}, 64'(bus.result), 64'(e.res));
    check({tag, ".overflow"}, 64'(bus.overflow), 64'(e.ovf));
    check({tag, ".div_by_zero"}, 64'(bus.div_by_zero), 64'(e.dz));
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".busy_held"}, 64'(busy_ok), 64'd1);
    check({tag, ".done_low_at_start"}, 64'(done_e0), 64'd0);
    check({tag, ".busy_low_at_done"}, 64'(bus.busy), 64'd0);
  endtask

  vec_t vecs[13];

  initial begin
    int           lat;
    bit           busy_ok, done_e0, saw_done;
    exp_t         e;
    logic         o;
    logic [W-1:0] aa, bb;

    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{1'b0, 28'h0018000, 28'hFFDC000, 28'hFFCA000, 1'b0, 1'b0};  // 1.5 * -2.25
    vecs[1]  = '{1'b1, 28'h00A0000, 28'h0040000, 28'h0028000, 1'b0, 1'b0};  // 10 / 4
    vecs[2]  = '{1'b1, 28'hFFF0000, 28'h0030000, 28'hFFFAAAB, 1'b0, 1'b0};  // -1 / 3
    vecs[3]  = '{1'b1, 28'hFFF0000, 28'h0000000, 28'h8000000, 1'b0, 1'b1};  // -1 / 0
    vecs[4]  = '{1'b1, 28'h0000000, 28'h0000000, 28'h7FFFFFF, 1'b0, 1'b1};  // 0 / 0
    vecs[5]  = '{1'b0, 28'h7FF0000, 28'h0020000, 28'h7FFFFFF, 1'b1, 1'b0};  // 2047 * 2
    vecs[6]  = '{1'b0, 28'h8000000, 28'h0010000, 28'h8000000, 1'b0, 1'b0};  // -2048 * 1
    vecs[7]  = '{1'b0, 28'h0000000, 28'hFFDC000, 28'h0000000, 1'b0, 1'b0};  // 0 * -2.25
    vecs[8]  = '{1'b1, 28'h0000000, 28'h0030000, 28'h0000000, 1'b0, 1'b0};  // 0 / 3
`ifdef FIXED_POINT_ROUND_EN
    vecs[9]  = '{1'b1, 28'h0020000, 28'h0030000, 28'h000AAAB, 1'b0, 1'b0};  // 2 / 3
    vecs[10] = '{1'b0, 28'h0000001, 28'h0008000, 28'h0000001, 1'b0, 1'b0};  // 2^-16 * 0.5
`else
    vecs[9]  = '{1'b1, 28'h0020000, 28'h0030000, 28'h000AAAA, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 28'h0000001, 28'h0008000, 28'h0000000, 1'b0, 1'b0};
`endif
    vecs[11] = '{1'b1, 28'h7FF0000, 28'h0000100, 28'h7FFFFFF, 1'b1, 1'b0};  // 2047 / 2^-8
    vecs[12] = '{1'b0, 28'h8000000, 28'hFFF0000, 28'h7FFFFFF, 1'b1, 1'b0};  // -2048 * -1

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", 64'(bus.busy), 64'd0);
    check("reset.done", 64'(bus.done), 64'd0);
    check("reset.result", 64'(bus.result), 64'd0);
    check("reset.overflow", 64'(bus.overflow), 64'd0);
    check("reset.div_by_zero", 64'(bus.div_by_zero), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      do_op(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 0, lat, busy_ok, done_e0);
      e = '{vecs[i].res, vecs[i].ovf, vecs[i].dz};
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].b, e, lat, busy_ok, done_e0);
    end

    // Stray start at cycle 5 of a multiply must be ignored.
    do_op(1'b1, 1'b0, 28'h0018000, 28'hFFDC000, 5, lat, busy_ok, done_e0);
    check_op("ignored_start", 1'b0, 28'hFFDC000, '{28'hFFCA000, 1'b0, 1'b0}, lat, busy_ok, done_e0);

    // Start during the done cycle is accepted: 2.0 * 3.0.
    do_op(1'b0, 1'b0, 28'h0020000, 28'h0030000, 0, lat, busy_ok, done_e0);
    check_op("back_to_back", 1'b0, 28'h0030000, '{28'h0060000, 1'b0, 1'b0}, lat, busy_ok, done_e0);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 28'h00A0000;
    bus.b     = 28'h0040000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort.busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.done", 64'(bus.done), 64'd0);
    check("abort.result", 64'(bus.result), 64'd0);
    check("abort.overflow", 64'(bus.overflow), 64'd0);
    @(negedge clk);
    reset    = 1'b0;
    saw_done = 1'b0;
    repeat (L_DIV + 4) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("abort.no_done", 64'(saw_done), 64'd0);
    do_op(1'b1, 1'b0, 28'h0018000, 28'hFFDC000, 0, lat, busy_ok, done_e0);
    check_op("after_reset", 1'b0, 28'hFFDC000, '{28'hFFCA000, 1'b0, 1'b0}, lat, busy_ok, done_e0);

    // Random operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      o  = 1'($urandom_range(0, 1));
      aa = W'($urandom);
      bb = W'($urandom);
      if ($urandom_range(0, 2) == 0) aa = W'($signed(aa) >>> $urandom_range(4, 20));
      if ($urandom_range(0, 2) != 0) bb = W'($signed(bb) >>> $urandom_range(4, 24));
      if ($urandom_range(0, 9) == 0) bb = '0;
      e = model(o, aa, bb);
      do_op(1'b1, o, aa, bb, 0, lat, busy_ok, done_e0);
      check_op($sformatf("rand%0d(op=%0d a=%h b=%h)", n, o, aa, bb), o, bb, e, lat, busy_ok, done_e0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
